// File: rtl/riscv_dcache_miss_ctrl.sv
// rtl/riscv_dcache_miss_ctrl.sv - data-cache miss controller (write-back victim, refill, install)
//
// Purpose: on a cache miss, writes the dirty victim block back to DRAM, reads
// the requested block, then pulses the data/tag array write enables for one
// cycle. The pipeline is stalled from the miss cycle until the install cycle.
//
// Ports:
//   clk, rst                    rising-edge clock, asynchronous active-low reset
//   cpu_wren/cpu_rden/cpu_addr  CPU access request (sampled only in IDLE)
//   hit, dirty                  tag-array lookup result and victim dirty bit
//   victim_tag/victim_block     victim line contents, latched on the miss
//   mem_wren/mem_rden/mem_addr  DRAM strobes and block address
//   mem_data_out/mem_data_in    write-back data / refill data
//   mem_ready                   DRAM transfer complete
//   refill_we/refill_block      data-array write enable and registered refill data
//   tag_we                      tag-array write enable ({valid=1, dirty=0, tag})
//   stall                       pipeline freeze
//   miss_count/wb_count         event counters, present only with MISS_CNT_EN
//
// Optional feature macro: MISS_CNT_EN (adds miss_count and wb_count outputs).

module riscv_dcache_miss_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int CACHE_SIZE = 4 * (2 ** 10),
  parameter int MEM_SIZE   = 4 * CACHE_SIZE,
  parameter int DATAPBLOCK = 16
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            cpu_wren,
  input  logic                                            cpu_rden,
  input  logic [$clog2(MEM_SIZE)-1:0]                     cpu_addr,
  input  logic                                            hit,
  input  logic                                            dirty,
  input  logic [$clog2(MEM_SIZE)-$clog2(CACHE_SIZE)-1:0]  victim_tag,
  input  logic [DATA_WIDTH-1:0]                           victim_block,
  output logic                                            mem_wren,
  output logic                                            mem_rden,
  output logic [$clog2(MEM_SIZE)-$clog2(DATAPBLOCK)-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]                           mem_data_out,
  input  logic [DATA_WIDTH-1:0]                           mem_data_in,
  input  logic                                            mem_ready,
  output logic                                            refill_we,
  output logic [DATA_WIDTH-1:0]                           refill_block,
  output logic                                            tag_we,
`ifdef MISS_CNT_EN
  output logic [31:0]                                     miss_count,
  output logic [31:0]                                     wb_count,
`endif
  output logic                                            stall
);

  localparam int CACHE_DEPTH = CACHE_SIZE / DATAPBLOCK;
  localparam int ADDR        = $clog2(MEM_SIZE);
  localparam int BYTE_OFF    = $clog2(DATAPBLOCK);
  localparam int INDEX       = $clog2(CACHE_DEPTH);
  localparam int TAG         = ADDR - BYTE_OFF - INDEX;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [TAG-1:0]        cpu_tag_q;
  logic [INDEX-1:0]      index_q;
  logic [TAG-1:0]        victim_tag_q;
  logic [DATA_WIDTH-1:0] victim_q;
  logic                  gap_q;
  logic                  miss;
  logic                  latch_en;
  logic                  wb_done;
  logic                  rd_done;

  // The byte offset within a block plays no part in a block-granular transfer.
  logic unused_offset;
  assign unused_offset = ^cpu_addr[BYTE_OFF-1:0];

  assign miss = (cpu_wren | cpu_rden) & ~hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cpu_tag_q    <= '0;
      index_q      <= '0;
      victim_tag_q <= '0;
      victim_q     <= '0;
      refill_block <= '0;
      gap_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      // gap_q holds off the read strobe for the first REFILL cycle after a
      // write-back so the DRAM sees the strobe fall and restarts its counter.
      gap_q   <= wb_done;
      if (latch_en) begin
        cpu_tag_q    <= cpu_addr[ADDR-1 -: TAG];
        index_q      <= cpu_addr[BYTE_OFF +: INDEX];
        victim_tag_q <= victim_tag;
        victim_q     <= victim_block;
      end
      if (rd_done) begin
        refill_block <= mem_data_in;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_wren     = 1'b0;
    mem_rden     = 1'b0;
    mem_addr     = '0;
    mem_data_out = '0;
    refill_we    = 1'b0;
    tag_we       = 1'b0;
    stall        = 1'b1;
    latch_en     = 1'b0;
    wb_done      = 1'b0;
    rd_done      = 1'b0;
    case (state_q)
      IDLE: begin
        stall = miss;
        if (miss) begin
          latch_en = 1'b1;
          state_d  = dirty ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        mem_wren     = 1'b1;
        mem_addr     = {victim_tag_q, index_q};
        mem_data_out = victim_q;
        if (mem_ready) begin
          wb_done = 1'b1;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (!gap_q) begin
          mem_rden = 1'b1;
          mem_addr = {cpu_tag_q, index_q};
          if (mem_ready) begin
            rd_done = 1'b1;
            state_d = UPDATE;
          end
        end
      end
      UPDATE: begin
        refill_we = 1'b1;
        tag_we    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MISS_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (latch_en) miss_count <= miss_count + 32'd1;
      if (wb_done)  wb_count   <= wb_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_dcache_miss_ctrl.sv
// tb/tb_riscv_dcache_miss_ctrl.sv - scoreboard bench for riscv_dcache_miss_ctrl

module tb_riscv_dcache_miss_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cpu_wren = 1'b0;
  logic         cpu_rden = 1'b0;
  logic [13:0]  cpu_addr = '0;
  logic         hit = 1'b0;
  logic         dirty = 1'b0;
  logic [1:0]   victim_tag = '0;
  logic [127:0] victim_block = '0;
  logic         mem_wren;
  logic         mem_rden;
  logic [9:0]   mem_addr;
  logic [127:0] mem_data_out;
  logic [127:0] mem_data_in = '0;
  logic         mem_ready;
  logic         refill_we;
  logic [127:0] refill_block;
  logic         tag_we;
  logic         stall;
`ifdef MISS_CNT_EN
  logic [31:0]  miss_count;
  logic [31:0]  wb_count;
`endif

  riscv_dcache_miss_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_wren     (cpu_wren),
    .cpu_rden     (cpu_rden),
    .cpu_addr     (cpu_addr),
    .hit          (hit),
    .dirty        (dirty),
    .victim_tag   (victim_tag),
    .victim_block (victim_block),
    .mem_wren     (mem_wren),
    .mem_rden     (mem_rden),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in),
    .mem_ready    (mem_ready),
    .refill_we    (refill_we),
    .refill_block (refill_block),
    .tag_we       (tag_we),
`ifdef MISS_CNT_EN
    .miss_count   (miss_count),
    .wb_count     (wb_count),
`endif
    .stall        (stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // DRAM model: mem_ready rises in the Nth consecutive cycle of a strobe.
  int lw = 1;
  int lr = 1;
  int cnt;
  assign mem_ready = (mem_wren && cnt == lw - 1) || (mem_rden && cnt == lr - 1);
  always @(posedge clk or negedge rst) begin
    if (!rst)                                     cnt <= 0;
    else if ((mem_wren || mem_rden) && !mem_ready) cnt <= cnt + 1;
    else                                          cnt <= 0;
  end

  // Scoreboard: kind 0 = write-back, 1 = refill read, 2 = array install.
  typedef struct {
    int           kind;
    logic [9:0]   addr;
    logic [127:0] data;
  } ev_t;
  ev_t exp_q[$];

  task automatic pop_cmp(input int kind, input logic [9:0] addr, input logic [127:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d addr %h, expected no event", kind, addr);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind != 2) check("event_addr", addr, e.addr);
      if (kind != 1) check("event_data", data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("strobes_exclusive", mem_wren & mem_rden, 0);
      if (mem_wren && mem_ready) pop_cmp(0, mem_addr, mem_data_out);
      if (mem_rden && mem_ready) pop_cmp(1, mem_addr, '0);
      if (refill_we) begin
        pop_cmp(2, '0, refill_block);
        check("tag_we_with_refill", tag_we, 1);
      end
    end
  end

  task automatic do_miss(input bit st, input logic [13:0] addr, input bit d,
                         input logic [1:0] vt, input logic [127:0] vb,
                         input int w, input int r, input logic [127:0] rd,
                         input logic [9:0] exp_wb_addr, input logic [9:0] exp_rd_addr,
                         input int exp_stall);
    ev_t e;
    int  n;
    bit  done;
    bit  prev_w;
    lw = w;
    lr = r;
    mem_data_in = rd;
    if (d) begin
      e.kind = 0; e.addr = exp_wb_addr; e.data = vb;
      exp_q.push_back(e);
    end
    e.kind = 1; e.addr = exp_rd_addr; e.data = '0;
    exp_q.push_back(e);
    e.kind = 2; e.addr = '0; e.data = rd;
    exp_q.push_back(e);
    cpu_addr = addr; dirty = d; victim_tag = vt; victim_block = vb;
    hit = 1'b0; cpu_wren = st; cpu_rden = !st;
    #1;
    n = 0; done = 0; prev_w = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (stall) n++;
      if (prev_w && !mem_wren) check("wb_gap_no_rden", mem_rden, 0);
      prev_w = mem_wren;
      if (refill_we) begin
        done = 1;
        hit = 1'b1;
      end
      @(negedge clk); #1;
    end
    check("miss_completed", done, 1);
    check("stall_cycles", n, exp_stall);
    check("replay_hit_no_stall", stall, 0);
    cpu_wren = 1'b0; cpu_rden = 1'b0; hit = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    bit any_refill;
    #3;
    check("rst_mem_wren", mem_wren, 0);
    check("rst_mem_rden", mem_rden, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data_out", mem_data_out, 0);
    check("rst_refill_we", refill_we, 0);
    check("rst_tag_we", tag_we, 0);
    check("rst_refill_block", refill_block, 0);
    check("rst_stall", stall, 0);
    @(negedge clk); #1;
    rst = 1'b1; hit = 1'b1; cpu_rden = 1'b1; cpu_wren = 1'b1; cpu_addr = 14'h1230;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hit_no_stall", stall, 0);
      check("hit_no_rden", mem_rden, 0);
      @(negedge clk); #1;
    end
    cpu_rden = 1'b0; cpu_wren = 1'b0; hit = 1'b0;
    @(negedge clk); #1;

    // Clean load miss, refill ready in the third rden cycle.
    do_miss(1'b0, 14'h1230, 1'b0, 2'b00, {16{8'h11}}, 1, 3,
            128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 10'h000, 10'h123, 5);
    // Dirty load miss: write back victim 2'b10 at index 8'h23, then refill.
    do_miss(1'b0, 14'h1230, 1'b1, 2'b10, {16{8'hA5}}, 2, 3,
            {4{32'hDEADBEEF}}, 10'h223, 10'h123, 8);
    // Clean store miss at the top block, single-cycle DRAM.
    do_miss(1'b1, 14'h3FF0, 1'b0, 2'b01, {16{8'h5A}}, 1, 1,
            {8{16'hC3C3}}, 10'h000, 10'h3FF, 3);
    check("refill_block_hold", refill_block, {8{16'hC3C3}});
`ifdef MISS_CNT_EN
    check("miss_count", miss_count, 3);
    check("wb_count", wb_count, 1);
`endif

    // Reset in the middle of a refill.
    lr = 10;
    cpu_addr = 14'h2450; dirty = 1'b0; hit = 1'b0; cpu_rden = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); #1;
      if (mem_rden) seen = 1;
    end
    check("reset_test_rden_seen", seen, 1);
    check("reset_test_rden_addr", mem_addr, 10'h245);
    @(negedge clk); #1;
    cpu_rden = 1'b0;
    rst = 1'b0;
    #1;
    check("midreset_rden", mem_rden, 0);
    check("midreset_stall", stall, 0);
    check("midreset_refill_block", refill_block, 0);
    check("midreset_mem_addr", mem_addr, 0);
`ifdef MISS_CNT_EN
    check("midreset_miss_count", miss_count, 0);
`endif
    @(negedge clk); #1;
    rst = 1'b1;
    any_refill = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk); #1;
      if (refill_we || tag_we || mem_rden || mem_wren || stall) any_refill = 1;
    end
    check("no_activity_after_reset", any_refill, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
